ofdm_frame_sequencer: RTL and testbench

//  Downstream of the start-extender. Turns the stretched start level into one OFDM transmit frame:

---
 rtl/ofdm_frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ofdm_frame_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_sequencer.sv
// rtl/ofdm_frame_sequencer.sv - OFDM transmit frame sequencer (preamble, payload, gap)
//
// Turns the rising edge of the stretched start level into one transmit frame:
// N_PRE preamble symbols, num_sym payload symbols paced by src_valid, then a
// GAP_LEN-cycle idle gap. Every symbol is CP_LEN + FFT_LEN samples long.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   start       in   stretched start level; rising edge triggers a frame
//   num_sym     in   payload symbol count, latched on an accepted trigger
//   src_valid   in   upstream payload sample available (DATA only)
//   busy        out  frame in progress (PRE, DATA or GAP)
//   phase       out  0=IDLE 1=PRE 2=DATA 3=GAP
//   samp_en     out  one sample consumed/produced this cycle
//   sym_start   out  samp_en on sample 0 of a symbol
//   cp_active   out  samp_en within the cyclic prefix
//   sym_idx     out  symbol index within the current phase
//   frame_done  out  1-cycle pulse on the first IDLE cycle after GAP
//   start_drop  out  1-cycle pulse when a trigger arrives while busy
module ofdm_frame_sequencer #(
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16,
  parameter int N_PRE   = 2,
  parameter int GAP_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] num_sym,
  input  logic       src_valid,
  output logic       busy,
  output logic [1:0] phase,
  output logic       samp_en,
  output logic       sym_start,
  output logic       cp_active,
  output logic [7:0] sym_idx,
  output logic       frame_done,
  output logic       start_drop
);

  localparam int SYM_LEN = CP_LEN + FFT_LEN;
  localparam int SW      = $clog2(SYM_LEN);
  localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [SW-1:0] SAMP_LAST = SW'(SYM_LEN - 1);
  localparam logic [SW-1:0] CP_END    = SW'(CP_LEN);
  localparam logic [7:0]    PRE_LAST  = 8'(N_PRE - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          start_d_q;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [7:0]    sym_idx_q, sym_idx_d;
  logic [7:0]    num_sym_q, num_sym_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          frame_done_q, frame_done_d;

  logic trig;
  logic sym_wrap;

  assign trig     = start & ~start_d_q;
  assign sym_wrap = samp_en && (samp_cnt_q == SAMP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_d_q    <= 1'b0;
      samp_cnt_q   <= '0;
      sym_idx_q    <= '0;
      num_sym_q    <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_d_q    <= start;
      samp_cnt_q   <= samp_cnt_d;
      sym_idx_q    <= sym_idx_d;
      num_sym_q    <= num_sym_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    samp_cnt_d   = samp_cnt_q;
    sym_idx_d    = sym_idx_q;
    num_sym_d    = num_sym_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;

    // Sample counter advances only on accepted samples, so a DATA stall
    // freezes the whole symbol position.
    if (samp_en) begin
      samp_cnt_d = sym_wrap ? '0 : samp_cnt_q + SW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d    = S_PRE;
          samp_cnt_d = '0;
          sym_idx_d  = '0;
          num_sym_d  = num_sym;
        end
      end
      S_PRE: begin
        if (sym_wrap) begin
          if (sym_idx_q == PRE_LAST) begin
            // Index restarts for the payload; with no payload go straight to the gap.
            sym_idx_d = '0;
            gap_cnt_d = '0;
            state_d   = (num_sym_q == 8'd0) ? S_GAP : S_DATA;
          end else begin
            sym_idx_d = sym_idx_q + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (sym_wrap) begin
          // Leaving on the last wrap keeps sym_idx from reaching num_sym.
          if (sym_idx_q == num_sym_q - 8'd1) begin
            sym_idx_d = '0;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            sym_idx_d = sym_idx_q + 8'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d    = '0;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign phase      = state_q;
  assign samp_en    = (state_q == S_PRE) || ((state_q == S_DATA) && src_valid);
  assign sym_start  = samp_en && (samp_cnt_q == '0);
  assign cp_active  = samp_en && (samp_cnt_q < CP_END);
  assign sym_idx    = sym_idx_q;
  assign frame_done = frame_done_q;
  assign start_drop = trig && (state_q != S_IDLE);

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// tb/tb_ofdm_frame_sequencer.sv - scoreboard testbench for ofdm_frame_sequencer
module tb_ofdm_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_sym;
  logic       src_valid;
  logic       busy;
  logic [1:0] phase;
  logic       samp_en;
  logic       sym_start;
  logic       cp_active;
  logic [7:0] sym_idx;
  logic       frame_done;
  logic       start_drop;

  ofdm_frame_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_sym    (num_sym),
    .src_valid  (src_valid),
    .busy       (busy),
    .phase      (phase),
    .samp_en    (samp_en),
    .sym_start  (sym_start),
    .cp_active  (cp_active),
    .sym_idx    (sym_idx),
    .frame_done (frame_done),
    .start_drop (start_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] idx;
  } sym_t;

  typedef struct {
    int en;
    int starts;
    int cp;
    int data_cyc;
    int data_en;
    int busy_cyc;
    int drops;
    int lat;
  } frm_t;

  sym_t sym_q[$];
  frm_t frm_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_syms(input int ns);
    for (int i = 0; i < 2; i++) sym_q.push_back({2'd1, 8'(i)});
    for (int i = 0; i < ns; i++) sym_q.push_back({2'd2, 8'(i)});
  endtask

  task automatic push_frame(input int en, input int starts, input int cp, input int data_cyc,
                            input int data_en, input int busy_cyc, input int drops, input int lat);
    frm_t f;
    f.en = en; f.starts = starts; f.cp = cp; f.data_cyc = data_cyc;
    f.data_en = data_en; f.busy_cyc = busy_cyc; f.drops = drops; f.lat = lat;
    frm_q.push_back(f);
  endtask

  // Monitor: samples on the falling edge, inputs only change just after the rising edge.
  int   cyc = 0;
  frm_t acc;
  int   first_en;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      acc = '{default: 0};
      first_en = -1;
    end else begin
      if (sym_start) begin
        if (sym_q.size() == 0) begin
          chk("unexpected_sym_start", 1, 0);
        end else begin
          sym_t e;
          e = sym_q.pop_front();
          chk("sym_phase", int'(phase), int'(e.ph));
          chk("sym_idx", int'(sym_idx), int'(e.idx));
        end
      end
      if (samp_en) begin
        acc.en++;
        if (first_en < 0) first_en = cyc;
      end
      if (sym_start)             acc.starts++;
      if (cp_active)             acc.cp++;
      if (phase == 2'd2)         acc.data_cyc++;
      if (phase == 2'd2 && samp_en) acc.data_en++;
      if (busy)                  acc.busy_cyc++;
      if (start_drop)            acc.drops++;
      if (frame_done) begin
        if (frm_q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          frm_t e;
          e = frm_q.pop_front();
          chk("frm_samp_en", acc.en, e.en);
          chk("frm_sym_starts", acc.starts, e.starts);
          chk("frm_cp_cycles", acc.cp, e.cp);
          chk("frm_data_cycles", acc.data_cyc, e.data_cyc);
          chk("frm_data_samp_en", acc.data_en, e.data_en);
          chk("frm_busy_cycles", acc.busy_cyc, e.busy_cyc);
          chk("frm_start_drops", acc.drops, e.drops);
          chk("frm_first_en_to_done", cyc - first_en, e.lat);
        end
        acc = '{default: 0};
        first_en = -1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (!frame_done && k < budget) begin
      step(1);
      k++;
    end
    if (!frame_done) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_phase(input string nm, input logic [1:0] p, input int budget);
    int k = 0;
    while (phase != p && k < budget) begin
      step(1);
      k++;
    end
    if (phase != p) chk({nm, "_phase_timeout"}, int'(phase), int'(p));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_phase"}, int'(phase), 0);
    chk({nm, "_samp_en"}, int'(samp_en), 0);
    chk({nm, "_cp_active"}, int'(cp_active), 0);
    chk({nm, "_sym_idx"}, int'(sym_idx), 0);
    chk({nm, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_sym   = 8'd3;
    src_valid = 1'b1;
    #1;
    check_all_zero("reset");
    step(3);
    rst_n = 1'b1;
    step(5);

    // T1: num_sym=3, continuous source
    push_syms(3);
    push_frame(400, 5, 80, 240, 240, 432, 0, 432);
    start = 1'b1;
    step(2);
    start = 1'b0;
    wait_done("t1", 600);

    // T5: num_sym=0, triggered in the frame_done cycle of T1
    num_sym = 8'd0;
    start   = 1'b1;
    push_syms(0);
    push_frame(160, 2, 32, 0, 0, 192, 0, 192);
    step(2);
    start = 1'b0;
    wait_done("t5", 300);
    step(4);

    // T2: num_sym=2, 7-cycle source stall at DATA sample 40
    num_sym = 8'd2;
    push_syms(2);
    push_frame(320, 4, 64, 167, 160, 359, 0, 359);
    start = 1'b1;
    step(2);
    start = 1'b0;
    wait_phase("t2", 2'd2, 300);
    step(40);
    src_valid = 1'b0;
    step(7);
    src_valid = 1'b1;
    wait_done("t2", 600);
    step(4);

    // T3: start held 1000 cycles, low, then high again -> exactly two frames
    num_sym = 8'd1;
    push_syms(1);
    push_frame(240, 3, 48, 80, 80, 272, 0, 272);
    push_syms(1);
    push_frame(240, 3, 48, 80, 80, 272, 0, 272);
    start = 1'b1;
    step(1000);
    start = 1'b0;
    step(10);
    start = 1'b1;
    wait_done("t3", 400);
    step(5);
    start = 1'b0;
    step(4);

    // T4: second edge mid-DATA is dropped; num_sym change mid-frame ignored
    num_sym = 8'd3;
    push_syms(3);
    push_frame(400, 5, 80, 240, 240, 432, 1, 432);
    start = 1'b1;
    step(2);
    start = 1'b0;
    wait_phase("t4", 2'd2, 300);
    step(100);
    start   = 1'b1;
    num_sym = 8'd7;
    step(1);
    start = 1'b0;
    wait_done("t4", 600);
    step(4);

    // T6: reset during the second preamble symbol, then a full frame
    num_sym = 8'd1;
    sym_q.push_back({2'd1, 8'd0});
    sym_q.push_back({2'd1, 8'd1});
    start = 1'b1;
    step(2);
    start = 1'b0;
    step(98);
    chk("t6_pre_sym_idx", int'(sym_idx), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    step(3);
    rst_n = 1'b1;
    step(5);
    push_syms(1);
    push_frame(240, 3, 48, 80, 80, 272, 0, 272);
    start = 1'b1;
    step(2);
    start = 1'b0;
    wait_done("t6", 400);
    step(4);

    // T7: num_sym=255, sym_idx runs to 254
    num_sym = 8'd255;
    push_syms(255);
    push_frame(20560, 257, 4112, 20400, 20400, 20592, 0, 20592);
    start = 1'b1;
    step(2);
    start = 1'b0;
    wait_done("t7", 21000);
    step(5);

    chk("sym_queue_empty", sym_q.size(), 0);
    chk("frame_queue_empty", frm_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
